eth_pcs_rx_block_lock_multi: RTL
================================

// Module: eth_pcs_rx_block_lock_multi
// PURPOSE
// Multi-lane, parametrised 64b/66b block-lock FSM (IEEE 802.3 Cl.49/82 style) for the RX PCS.
// Per lane: tests 2-bit sync headers, drives a slip request to the upstream gearbox, and reports lock.
// Adds three features: a post-slip hold-off window, a global relock command, and a saturating
// lock-loss event counter. Sits between the RX gearbox(es) and the descrambler/decoder.
// PARAMETERS
// N_LANES       4   number of independent lanes (>=1)
// SH_CNT_MAX    64  headers per test window (>=2)
// SH_INVAL_MAX  16  invalid headers per window that drop lock once locked (1..SH_CNT_MAX)
// SLIP_WAIT     2   valid beats ignored after a slip while the gearbox realigns (>=0)
// W_LOSS_CNT    16  width of the lock-loss event counter
// PORTS
// i_clk            in   1                 clock
// i_reset          in   1                 synchronous, active-high reset
// i_valid          in   N_LANES           per-lane header-valid strobe
// i_sync_hdr       in   N_LANES*W_SYNC    lane i header = [i*W_SYNC +: W_SYNC]
// i_relock         in   1                 pulse: force all lanes to S_INIT
// i_cnt_clr        in   1                 pulse: clear o_loss_cnt
// o_slip           out  N_LANES           registered one-cycle slip request per lane
// o_rx_lock        out  N_LANES           per-lane block lock
// o_all_lock       out  1                 &o_rx_lock (combinational from registered lock)
// o_loss_cnt       out  W_LOSS_CNT        saturating count of lock 1->0 transitions, all lanes
// BEHAVIOUR
// - Reset: all lanes in S_INIT; counters 0; o_slip=0, o_rx_lock=0, o_all_lock=0, o_loss_cnt=0.
// - Header is good iff it equals SYNC_CTRL (2'b10) or SYNC_DATA (2'b01). 00/11 are bad.
// - State changes only on beats where that lane's i_valid=1. Exceptions: S_INIT, reset, relock.
// - S_INIT: clears sh_cnt, inval_cnt and lock. Moves to S_TEST on the next clock, independent of valid.
// - S_TEST, per valid beat (sh_cnt counts beats in the window, 0..SH_CNT_MAX-1):
//   * Good header at sh_cnt==SH_CNT_MAX-1: window ends, both counters cleared.
//     If inval_cnt==0, lock<=1.
//   * Good header otherwise: sh_cnt++.
//   * Bad header while unlocked: slip.
//   * Bad header while locked with inval_cnt==SH_INVAL_MAX-1: slip.
//   * Slip means lock<=0, counters cleared, o_slip pulses next cycle. Next state is S_WAIT, or S_TEST if SLIP_WAIT==0.
//   * Bad header, locked, threshold not reached: inval_cnt++ and sh_cnt++.
//     If sh_cnt==SH_CNT_MAX-1, the window ends instead: counters cleared, lock held.
// - S_WAIT: counts SLIP_WAIT valid beats, ignoring their headers. After the last one, returns to S_TEST.
//   No slip is issued from S_WAIT.
// - Latency: lock rises, lock falls and o_slip pulse all appear 1 clock after the deciding valid beat.
// - From reset with all good headers: o_rx_lock rises 1 clk after the SH_CNT_MAX-th valid beat.
// - i_relock: all lanes go to S_INIT next clock, lock cleared. Overrides a same-cycle slip: no o_slip pulse.
//   A lock drop caused by relock does count as a loss event.
// - o_loss_cnt:
//   * Each cycle it adds popcount(lanes whose lock goes 1->0), saturating at all-ones.
//   * i_cnt_clr has priority: that cycle loads 0 and discards events.
// - Lanes are fully independent. Simultaneous slips on several lanes are all reported in the same cycle.
// - i_reset mid-window or mid-S_WAIT: immediate return to the reset state; no o_slip pulse.
// STRUCTURE
// - eth_pcs_params package (existing): W_SYNC, SYNC_CTRL, SYNC_DATA.
//   Add: typedef enum logic [1:0] {S_INIT, S_TEST, S_WAIT} blk_lock_state_t.
// - Counter widths: $clog2(SH_CNT_MAX), $clog2(SH_INVAL_MAX+1), $clog2(SLIP_WAIT+1). Local to the lane module.
// - Sub-module eth_pcs_rx_block_lock_lane: one FSM, counters and registered slip/lock.
//   Top instantiates it N_LANES times via generate, plus the popcount and saturating loss counter.
// TESTING (defaults N_LANES=4, SH_CNT_MAX=64, SH_INVAL_MAX=16, SLIP_WAIT=2)
// - Acquire: reset, then 64 valid good headers on all lanes.
//   -> o_rx_lock=4'hF and o_all_lock=1 one clk after the 64th beat; o_slip never pulses.
// - Unlocked slip: lane 1 header 2'b00 at beat 10.
//   -> o_slip[1] high 1 clk; next 2 valid beats ignored (even if bad).
//   -> lane 1 locks 64 good beats after the hold-off; lanes 0,2,3 unaffected.
// - Loss threshold: locked lane 0, 15 bad headers in one window -> lock held, window resets.
//   -> 16 bad in one window: o_rx_lock[0]=0 and o_slip[0]=1 one clk after the 16th; o_loss_cnt=1.
// - Valid gaps: i_valid toggled 1/0 during acquire -> lock after exactly 64 valid beats.
//   -> counters frozen while i_valid=0.
// - Relock vs slip: i_relock in the same cycle a lane hits its slip condition.
//   -> no o_slip pulse; all locks 0; o_loss_cnt += number of previously locked lanes.
// - Counter: W_LOSS_CNT=2, force 5 losses -> o_loss_cnt saturates at 3.
//   -> i_cnt_clr together with a loss event -> o_loss_cnt=0.

Source files
------------

// File: rtl/eth_pcs_rx_block_lock_multi_pkg.sv
// Shared RX PCS definitions: sync-header encoding and the block-lock FSM state type.
package eth_pcs_params;

  localparam int W_SYNC = 2;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;
  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_TEST = 2'd1,
    S_WAIT = 2'd2
  } blk_lock_state_t;

  function automatic logic sh_is_good(input logic [W_SYNC-1:0] hdr);
    return (hdr == SYNC_CTRL) || (hdr == SYNC_DATA);
  endfunction

endpackage

// File: rtl/eth_pcs_rx_block_lock_multi_if.sv
// Gearbox <-> block-lock lane bundle: per-lane header strobes in, slip/lock back.
interface eth_pcs_rx_block_lock_multi_if #(
  parameter int N_LANES = 4
);
  import eth_pcs_params::*;

  logic [N_LANES-1:0]        i_valid;
  logic [N_LANES*W_SYNC-1:0] i_sync_hdr;
  logic [N_LANES-1:0]        o_slip;
  logic [N_LANES-1:0]        o_rx_lock;

  modport master (output i_valid, output i_sync_hdr, input o_slip, input o_rx_lock);
  modport slave  (input i_valid, input i_sync_hdr, output o_slip, output o_rx_lock);

endinterface

// File: rtl/eth_pcs_rx_block_lock_lane.sv
// Single-lane 64b/66b block-lock FSM with post-slip hold-off and registered slip/lock.
module eth_pcs_rx_block_lock_lane
  import eth_pcs_params::*;
#(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVAL_MAX = 16,
  parameter int SLIP_WAIT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [W_SYNC-1:0] sync_hdr,
  input  logic              relock,
  output logic              slip,
  output logic              lock,
  output logic              lock_fall
);

  localparam int W_SH   = $clog2(SH_CNT_MAX);
  localparam int W_INV  = $clog2(SH_INVAL_MAX + 1);
  localparam int W_WAIT = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

  localparam logic [W_SH-1:0]   SH_LAST   = W_SH'(SH_CNT_MAX - 1);
  localparam logic [W_INV-1:0]  INV_LAST  = W_INV'(SH_INVAL_MAX - 1);
  localparam logic [W_WAIT-1:0] WAIT_LAST = W_WAIT'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);

  blk_lock_state_t   state_r, state_s;
  logic [W_SH-1:0]   sh_cnt_r, sh_cnt_s;
  logic [W_INV-1:0]  inv_cnt_r, inv_cnt_s;
  logic [W_WAIT-1:0] wait_cnt_r, wait_cnt_s;
  logic              lock_r, lock_s;
  logic              slip_r, slip_s;

  // Next-state logic; relock overrides everything, including a same-cycle slip.
  always_comb begin
    state_s    = state_r;
    sh_cnt_s   = sh_cnt_r;
    inv_cnt_s  = inv_cnt_r;
    wait_cnt_s = wait_cnt_r;
    lock_s     = lock_r;
    slip_s     = 1'b0;
    if (relock) begin
      state_s    = S_INIT;
      sh_cnt_s   = '0;
      inv_cnt_s  = '0;
      wait_cnt_s = '0;
      lock_s     = 1'b0;
    end else begin
      case (state_r)
        S_INIT: begin
          sh_cnt_s   = '0;
          inv_cnt_s  = '0;
          wait_cnt_s = '0;
          lock_s     = 1'b0;
          state_s    = S_TEST;
        end
        S_TEST: begin
          if (!valid) begin
            state_s = S_TEST;
          end else if (sh_is_good(sync_hdr)) begin
            if (sh_cnt_r == SH_LAST) begin
              sh_cnt_s  = '0;
              inv_cnt_s = '0;
              if (inv_cnt_r == '0) lock_s = 1'b1;
              else                 lock_s = lock_r;
            end else begin
              sh_cnt_s = sh_cnt_r + W_SH'(1);
            end
          end else if (!lock_r || (inv_cnt_r == INV_LAST)) begin
            sh_cnt_s   = '0;
            inv_cnt_s  = '0;
            wait_cnt_s = '0;
            lock_s     = 1'b0;
            slip_s     = 1'b1;
            state_s    = (SLIP_WAIT == 0) ? S_TEST : S_WAIT;
          end else if (sh_cnt_r == SH_LAST) begin
            // Window closes on a tolerated bad header: lock is kept.
            sh_cnt_s  = '0;
            inv_cnt_s = '0;
          end else begin
            sh_cnt_s  = sh_cnt_r + W_SH'(1);
            inv_cnt_s = inv_cnt_r + W_INV'(1);
          end
        end
        S_WAIT: begin
          if (!valid) begin
            state_s = S_WAIT;
          end else if (wait_cnt_r == WAIT_LAST) begin
            wait_cnt_s = '0;
            state_s    = S_TEST;
          end else begin
            wait_cnt_s = wait_cnt_r + W_WAIT'(1);
          end
        end
        default: begin
          state_s = S_INIT;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_INIT;
      sh_cnt_r   <= '0;
      inv_cnt_r  <= '0;
      wait_cnt_r <= '0;
      lock_r     <= 1'b0;
      slip_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      sh_cnt_r   <= sh_cnt_s;
      inv_cnt_r  <= inv_cnt_s;
      wait_cnt_r <= wait_cnt_s;
      lock_r     <= lock_s;
      slip_r     <= slip_s;
    end
  end

  assign slip      = slip_r;
  assign lock      = lock_r;
  assign lock_fall = lock_r & ~lock_s;

endmodule

// File: rtl/eth_pcs_rx_block_lock_multi.sv
// Multi-lane RX block lock: independent per-lane FSMs plus a saturating lock-loss counter.
module eth_pcs_rx_block_lock_multi
  import eth_pcs_params::*;
#(
  parameter int N_LANES      = 4,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVAL_MAX = 16,
  parameter int SLIP_WAIT    = 2,
  parameter int W_LOSS_CNT   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  eth_pcs_rx_block_lock_multi_if.slave  lanes,
  input  logic                          i_relock,
  input  logic                          i_cnt_clr,
  output logic                          o_all_lock,
  output logic [W_LOSS_CNT-1:0]         o_loss_cnt
);

  localparam int W_POP = $clog2(N_LANES + 1);
  localparam int W_SUM = ((W_LOSS_CNT > W_POP) ? W_LOSS_CNT : W_POP) + 1;
  localparam logic [W_SUM-1:0] LOSS_MAX = {{(W_SUM - W_LOSS_CNT){1'b0}}, {W_LOSS_CNT{1'b1}}};

  logic [N_LANES-1:0]    slip_s, lock_s, fall_s;
  logic [W_POP-1:0]      pop_s;
  logic [W_SUM-1:0]      sum_s;
  logic [W_LOSS_CNT-1:0] loss_cnt_r;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    eth_pcs_rx_block_lock_lane #(
      .SH_CNT_MAX  (SH_CNT_MAX),
      .SH_INVAL_MAX(SH_INVAL_MAX),
      .SLIP_WAIT   (SLIP_WAIT)
    ) u_lane (
      .clk      (i_clk),
      .reset    (i_reset),
      .valid    (lanes.i_valid[g]),
      .sync_hdr (lanes.i_sync_hdr[g*W_SYNC +: W_SYNC]),
      .relock   (i_relock),
      .slip     (slip_s[g]),
      .lock     (lock_s[g]),
      .lock_fall(fall_s[g])
    );
  end

  // Number of lanes losing lock this cycle, added onto the running count.
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < N_LANES; i++) begin
      pop_s = pop_s + W_POP'(fall_s[i]);
    end
    sum_s = W_SUM'(loss_cnt_r) + W_SUM'(pop_s);
  end

  // Saturating loss counter; a clear request discards same-cycle events.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_cnt_clr) begin
      loss_cnt_r <= '0;
    end else if (sum_s > LOSS_MAX) begin
      loss_cnt_r <= '1;
    end else begin
      loss_cnt_r <= sum_s[W_LOSS_CNT-1:0];
    end
  end

  assign lanes.o_slip    = slip_s;
  assign lanes.o_rx_lock = lock_s;
  assign o_all_lock      = &lock_s;
  assign o_loss_cnt      = loss_cnt_r;

endmodule
